// File: rtl/npc_exec_sequencer.sv
// Multi-cycle control sequencer for the NPC datapath: fetch handshake, data-memory
// wait, single-retire gating of PC/register-file writes, halt/timeout and counters.
module npc_exec_sequencer #(
  parameter int unsigned IMEM_TIMEOUT = 255,
  parameter int unsigned CNT_W        = 32,
  parameter logic [31:0] EBREAK_INST  = 32'h0010_0073
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      pc,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ready,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      inst,
  input  logic             dec_RegWr,
  input  logic             dec_MemWr,
  input  logic             dec_MemtoReg,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             rf_wen,
  output logic             halted,
  output logic             err,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_EXEC,
    S_MEM,
    S_HALT,
    S_ERROR
  } state_t;

  localparam logic [31:0] NOP_INST  = 32'h0000_0013;
  localparam logic [15:0] TMO_LIMIT = 16'(IMEM_TIMEOUT);

  state_t      state, state_nxt;
  logic [15:0] tmo_cnt;
  logic        inst_load, tmo_clr, tmo_inc, retire;
  logic        imem_req_raw, dmem_req_raw, dmem_we_raw, pc_en_raw, rf_wen_raw;

  // NOTE: every signal driven here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_nxt    = state;
    inst_load    = 1'b0;
    tmo_clr      = 1'b0;
    tmo_inc      = 1'b0;
    retire       = 1'b0;
    imem_req_raw = 1'b0;
    dmem_req_raw = 1'b0;
    dmem_we_raw  = 1'b0;
    pc_en_raw    = 1'b0;
    rf_wen_raw   = 1'b0;
    unique case (state)
      S_FETCH: begin
        imem_req_raw = 1'b1;
        // A ready on the limit cycle still wins over the timeout.
        if (imem_ready) begin
          inst_load = 1'b1;
          tmo_clr   = 1'b1;
          state_nxt = S_EXEC;
        end else if (tmo_cnt == TMO_LIMIT) begin
          state_nxt = S_ERROR;
        end else begin
          tmo_inc = 1'b1;
        end
      end
      S_EXEC: begin
        if (inst == EBREAK_INST) begin
          retire    = 1'b1;
          state_nxt = S_HALT;
        end else if (dec_MemtoReg || dec_MemWr) begin
          state_nxt = S_MEM;
        end else begin
          pc_en_raw  = 1'b1;
          rf_wen_raw = dec_RegWr;
          retire     = 1'b1;
          state_nxt  = S_FETCH;
        end
      end
      S_MEM: begin
        dmem_req_raw = 1'b1;
        dmem_we_raw  = dec_MemWr;
        if (dmem_ready) begin
          pc_en_raw  = 1'b1;
          // Conflicting decode (load and store together) resolves as a store.
          rf_wen_raw = dec_RegWr & dec_MemtoReg & ~dec_MemWr;
          retire     = 1'b1;
          tmo_clr    = 1'b1;
          state_nxt  = S_FETCH;
        end else if (tmo_cnt == TMO_LIMIT) begin
          state_nxt = S_ERROR;
        end else begin
          tmo_inc = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_FETCH;
      inst        <= NOP_INST;
      tmo_cnt     <= '0;
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (inst_load) inst <= imem_rdata;
      if (tmo_clr)      tmo_cnt <= '0;
      else if (tmo_inc) tmo_cnt <= tmo_cnt + 16'd1;
      if (state != S_HALT && state != S_ERROR) cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (retire) instret_cnt <= instret_cnt + CNT_W'(1);
    end
  end

  // Requests and enables are suppressed in the reset cycle, whatever the old state.
  assign imem_req  = imem_req_raw & ~rst;
  assign imem_addr = imem_req ? pc : 32'h0;
  assign dmem_req  = dmem_req_raw & ~rst;
  assign dmem_we   = dmem_we_raw & ~rst;
  assign pc_en     = pc_en_raw & ~rst;
  assign rf_wen    = rf_wen_raw & ~rst;
  assign halted    = (state == S_HALT);
  assign err       = (state == S_ERROR);

endmodule

// File: tb/tb_npc_exec_sequencer.sv
// Directed bench for npc_exec_sequencer: ALU, stalled fetch, load/store, ebreak,
// fetch timeout and reset in the middle of a data access.
module tb_npc_exec_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic        dec_RegWr, dec_MemWr, dec_MemtoReg;
  logic        dmem_req, dmem_we, dmem_ready;
  logic        pc_en, rf_wen, halted, err;
  logic [31:0] cycle_cnt, instret_cnt;

  int n_vec  = 0;
  int n_miss = 0;

  npc_exec_sequencer #(.IMEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .pc(pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .inst(inst),
    .dec_RegWr(dec_RegWr), .dec_MemWr(dec_MemWr), .dec_MemtoReg(dec_MemtoReg),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
    .pc_en(pc_en), .rf_wen(rf_wen), .halted(halted), .err(err),
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_dec();
    dec_RegWr    = 1'b0;
    dec_MemWr    = 1'b0;
    dec_MemtoReg = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_imem_req", imem_req, 0);
    check("rst_dmem_req", dmem_req, 0);
    check("rst_pc_en", pc_en, 0);
    check("rst_rf_wen", rf_wen, 0);
    tick();
    rst        = 1'b0;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    clear_dec();
  endtask

  initial begin
    rst = 1'b1; pc = '0; imem_ready = 1'b0; imem_rdata = '0;
    dmem_ready = 1'b0;
    clear_dec();
    tick();
    do_reset();
    check("reset_cycle", cycle_cnt, 0);
    check("reset_instret", instret_cnt, 0);
    check("reset_inst", inst, 32'h0000_0013);
    check("reset_halted", halted, 0);
    check("reset_err", err, 0);

    // ALU op with zero-wait fetch
    pc = 32'h100; imem_ready = 1'b1; imem_rdata = 32'h0050_0093;
    #1;
    check("alu_imem_req", imem_req, 1);
    check("alu_imem_addr", imem_addr, 32'h100);
    check("alu_fetch_pc_en", pc_en, 0);
    tick();
    imem_ready = 1'b0; dec_RegWr = 1'b1;
    #1;
    check("alu_inst", inst, 32'h0050_0093);
    check("alu_pc_en", pc_en, 1);
    check("alu_rf_wen", rf_wen, 1);
    check("alu_exec_imem_req", imem_req, 0);
    check("alu_exec_imem_addr", imem_addr, 0);
    tick();
    clear_dec();
    #1;
    check("alu_instret", instret_cnt, 1);
    check("alu_cycle", cycle_cnt, 2);

    // Fetch stalled three cycles
    pc = 32'h104; imem_rdata = 32'h00a0_0113;
    for (int i = 0; i < 4; i++) begin
      imem_ready = (i == 3);
      #1;
      check("stall_imem_req", imem_req, 1);
      check("stall_imem_addr", imem_addr, 32'h104);
      check("stall_inst_held", inst, 32'h0050_0093);
      check("stall_pc_en", pc_en, 0);
      tick();
    end
    imem_ready = 1'b0; dec_RegWr = 1'b1;
    #1;
    check("stall_inst", inst, 32'h00a0_0113);
    check("stall_exec_pc_en", pc_en, 1);
    tick();
    clear_dec();
    #1;
    check("stall_instret", instret_cnt, 2);
    check("stall_cycle", cycle_cnt, 7);

    // Load with dmem_ready after two wait cycles
    pc = 32'h108; imem_ready = 1'b1; imem_rdata = 32'h0000_a183;
    tick();
    imem_ready = 1'b0; dec_MemtoReg = 1'b1; dec_RegWr = 1'b1;
    #1;
    check("ld_exec_pc_en", pc_en, 0);
    check("ld_exec_rf_wen", rf_wen, 0);
    check("ld_exec_dmem_req", dmem_req, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      dmem_ready = (i == 2);
      #1;
      check("ld_dmem_req", dmem_req, 1);
      check("ld_dmem_we", dmem_we, 0);
      check("ld_imem_req", imem_req, 0);
      check("ld_pc_en", pc_en, (i == 2));
      check("ld_rf_wen", rf_wen, (i == 2));
      tick();
    end
    dmem_ready = 1'b0; clear_dec();
    #1;
    check("ld_instret", instret_cnt, 3);
    check("ld_cycle", cycle_cnt, 12);

    // Store with conflicting load flag: treated as a store
    pc = 32'h10c; imem_ready = 1'b1; imem_rdata = 32'h0020_a023;
    tick();
    imem_ready = 1'b0; dec_MemWr = 1'b1; dec_MemtoReg = 1'b1; dec_RegWr = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) begin
      dmem_ready = (i == 1);
      #1;
      check("st_dmem_req", dmem_req, 1);
      check("st_dmem_we", dmem_we, 1);
      check("st_pc_en", pc_en, (i == 1));
      check("st_rf_wen", rf_wen, 0);
      tick();
    end
    dmem_ready = 1'b0; clear_dec();
    #1;
    check("st_instret", instret_cnt, 4);
    check("st_cycle", cycle_cnt, 16);

    // ebreak halts with counters frozen
    pc = 32'h110; imem_ready = 1'b1; imem_rdata = 32'h0010_0073;
    tick();
    #1;
    check("ebk_exec_pc_en", pc_en, 0);
    check("ebk_exec_rf_wen", rf_wen, 0);
    tick();
    for (int i = 0; i < 10; i++) begin
      #1;
      check("ebk_halted", halted, 1);
      check("ebk_pc_en", pc_en, 0);
      check("ebk_imem_req", imem_req, 0);
      check("ebk_cycle", cycle_cnt, 18);
      check("ebk_instret", instret_cnt, 5);
      tick();
    end

    // Fetch timeout: limit 4 means five waiting cycles, then ERROR
    do_reset();
    check("tmo_halted_cleared", halted, 0);
    for (int i = 0; i < 5; i++) begin
      #1;
      check("tmo_wait_req", imem_req, 1);
      check("tmo_wait_err", err, 0);
      tick();
    end
    #1;
    check("tmo_err", err, 1);
    check("tmo_halted", halted, 0);
    check("tmo_imem_req", imem_req, 0);
    check("tmo_cycle", cycle_cnt, 5);
    tick();
    check("tmo_err_sticky", err, 1);
    check("tmo_cycle_frozen", cycle_cnt, 5);

    // Ready exactly on the limit cycle: fetch accepted
    do_reset();
    check("lim_err_cleared", err, 0);
    imem_rdata = 32'h0020_8233;
    for (int i = 0; i < 5; i++) begin
      imem_ready = (i == 4);
      #1;
      check("lim_wait_err", err, 0);
      tick();
    end
    imem_ready = 1'b0;
    #1;
    check("lim_err", err, 0);
    check("lim_inst", inst, 32'h0020_8233);
    check("lim_exec_imem_req", imem_req, 0);

    // Reset in the middle of a data access
    dec_MemtoReg = 1'b1;
    tick();
    #1;
    check("midmem_dmem_req", dmem_req, 1);
    do_reset();
    #1;
    check("post_imem_req", imem_req, 1);
    check("post_dmem_req", dmem_req, 0);
    check("post_cycle", cycle_cnt, 0);
    check("post_instret", instret_cnt, 0);
    check("post_halted", halted, 0);
    check("post_err", err, 0);
    check("post_inst", inst, 32'h0000_0013);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
